// File: rtl/cipu_out_arbiter_if.sv
// Bus bundle for the CIPU output arbiter.
// Source side: src_valid/src_data/src_done in, src_ready out.
// Sink side:   out_valid/out_data/out_src out, out_ready in.
// Status:      done_src/done_all/overflow out.
// Modports: slave = arbiter view, master = producer/sink view.
interface cipu_out_arbiter_if #(
  parameter int unsigned DW = 8
);
  logic [2:0]      src_valid;
  logic [3*DW-1:0] src_data;
  logic [2:0]      src_done;
  logic [2:0]      src_ready;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic [1:0]      out_src;
  logic            out_ready;
  logic [2:0]      done_src;
  logic            done_all;
  logic [2:0]      overflow;

  modport slave (
    input  src_valid, src_data, src_done, out_ready,
    output src_ready, out_valid, out_data, out_src, done_src, done_all, overflow
  );

  modport master (
    output src_valid, src_data, src_done, out_ready,
    input  src_ready, out_valid, out_data, out_src, done_src, done_all, overflow
  );
endinterface

// File: rtl/cipu_out_arbiter.sv
// Shares one result bus between the three CIPU result channels
// (0 = people FIFO, 1 = thing LIFO, 2 = thing FIFO2).
// Each channel feeds a DEPTH-entry queue; queue heads are granted
// round-robin into a registered valid/ready output stage.
// Ports: clk, rst (synchronous, active-low), bus (cipu_out_arbiter_if.slave):
//   src_valid/src_data/src_done/src_ready per source, out_valid/out_data/
//   out_src/out_ready toward the sink, done_src/done_all/overflow status.
module cipu_out_arbiter #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = 8
) (
  input logic               clk,
  input logic               rst,
  cipu_out_arbiter_if.slave bus
);
  localparam int unsigned NSRC = 3;
  localparam int unsigned PW   = $clog2(DEPTH);
  localparam int unsigned CW   = PW + 1;

  logic [NSRC-1:0][DEPTH-1:0][DW-1:0] mem_q, mem_d;
  logic [NSRC-1:0][PW-1:0]            wr_ptr_q, wr_ptr_d;
  logic [NSRC-1:0][PW-1:0]            rd_ptr_q, rd_ptr_d;
  logic [NSRC-1:0][CW-1:0]            cnt_q, cnt_d;
  logic                               out_valid_q, out_valid_d;
  logic [DW-1:0]                      out_data_q, out_data_d;
  logic [1:0]                         out_src_q, out_src_d;
  logic [1:0]                         rr_q, rr_d;
  logic [NSRC-1:0]                    seen_done_q, seen_done_d;
  logic [NSRC-1:0]                    done_src_q, done_src_d;
  logic                               done_all_q, done_all_d;
  logic [NSRC-1:0]                    overflow_q, overflow_d;

  logic [NSRC-1:0] src_ready_c;
  logic [NSRC-1:0] push_c;
  logic [NSRC-1:0] pop_c;
  logic [NSRC-1:0] drained_c;
  logic            load_c;
  logic            gnt_vld_c;
  logic [1:0]      gnt_idx_c;
  logic [2:0]      scan_sum_c;
  logic [1:0]      scan_idx_c;

  // Queue not full; deliberately ignores a same-cycle pop.
  always_comb begin
    for (int i = 0; i < int'(NSRC); i++) begin
      src_ready_c[i] = (cnt_q[i] != CW'(DEPTH));
    end
  end

  // Round-robin scan rr, rr+1, rr+2; the lowest offset with data wins.
  always_comb begin
    gnt_vld_c  = 1'b0;
    gnt_idx_c  = 2'd0;
    scan_sum_c = 3'd0;
    scan_idx_c = 2'd0;
    for (int k = int'(NSRC) - 1; k >= 0; k--) begin
      scan_sum_c = 3'({1'b0, rr_q}) + 3'(k);
      scan_idx_c = (scan_sum_c >= 3'd3) ? 2'(scan_sum_c - 3'd3) : 2'(scan_sum_c);
      if (cnt_q[scan_idx_c] != CW'(0)) begin
        gnt_vld_c = 1'b1;
        gnt_idx_c = scan_idx_c;
      end
    end
  end

  // Next-state: output stage, queue push/pop, overflow and done tracking.
  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    rr_d        = rr_q;
    seen_done_d = seen_done_q;
    done_src_d  = done_src_q;
    done_all_d  = done_all_q;
    overflow_d  = overflow_q;
    push_c      = '0;
    pop_c       = '0;
    drained_c   = '0;

    // Stage reloads when empty or being consumed this cycle.
    load_c = !out_valid_q || bus.out_ready;
    if (load_c) begin
      if (gnt_vld_c) begin
        out_valid_d      = 1'b1;
        out_data_d       = mem_q[gnt_idx_c][rd_ptr_q[gnt_idx_c]];
        out_src_d        = gnt_idx_c;
        rr_d             = (gnt_idx_c == 2'd2) ? 2'd0 : gnt_idx_c + 2'd1;
        pop_c[gnt_idx_c] = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end

    for (int i = 0; i < int'(NSRC); i++) begin
      push_c[i] = bus.src_valid[i] && src_ready_c[i];
      if (push_c[i]) begin
        mem_d[i][wr_ptr_q[i]] = bus.src_data[DW*i +: DW];
        wr_ptr_d[i]           = wr_ptr_q[i] + PW'(1);
      end
      if (pop_c[i]) begin
        rd_ptr_d[i] = rd_ptr_q[i] + PW'(1);
      end
      cnt_d[i] = cnt_q[i] + CW'(push_c[i]) - CW'(pop_c[i]);

      // Dropped word, or a word arriving after the channel reported done.
      if (bus.src_valid[i] && (!src_ready_c[i] || done_src_q[i])) begin
        overflow_d[i] = 1'b1;
      end

      seen_done_d[i] = seen_done_q[i] | bus.src_done[i];
      drained_c[i]   = seen_done_q[i] && (cnt_q[i] == CW'(0)) &&
                       !(out_valid_q && (out_src_q == 2'(i)));
      done_src_d[i]  = done_src_q[i] | drained_c[i];
    end
    done_all_d = &drained_c;
  end

  // State registers with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= 2'd0;
      rr_q        <= 2'd0;
      seen_done_q <= '0;
      done_src_q  <= '0;
      done_all_q  <= 1'b0;
      overflow_q  <= '0;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      rr_q        <= rr_d;
      seen_done_q <= seen_done_d;
      done_src_q  <= done_src_d;
      done_all_q  <= done_all_d;
      overflow_q  <= overflow_d;
    end
  end

  assign bus.src_ready = src_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_src   = out_src_q;
  assign bus.done_src  = done_src_q;
  assign bus.done_all  = done_all_q;
  assign bus.overflow  = overflow_q;
endmodule

// File: doc/cipu_out_arbiter.md
Name: cipu_out_arbiter

Overview:
- Shares one 8-bit result bus between the three CIPU result channels: people FIFO (src 0), thing LIFO (src 1) and thing FIFO2 (src 2).
- Each channel has a small input queue. Queued words are granted round-robin into a registered output stage with a valid/ready handshake toward the sink.
- Per-channel and global done flags are produced once every word of a channel has left the block.
- Sits between the CIPU result outputs and the downstream checker/collector.

Parameters:
- DEPTH, 4: entries per source queue, power of two, minimum 2.
- DW, 8: data width per source.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-low.
- src_valid  in  3  per-source word strobe; bit i belongs to source i.
- src_data  in  3*DW  packed source data; source i uses [DW*i+DW-1 : DW*i].
- src_done  in  3  per-source end-of-stream pulse or level; latched sticky.
- src_ready  out  3  bit i = queue i not full; combinational from the registered count.
- out_valid  out  1  output word valid.
- out_data  out  DW  output word.
- out_src  out  2  source index of out_data (0, 1 or 2).
- out_ready  in  1  sink accepts the word when out_valid && out_ready at posedge.
- done_src  out  3  registered; bit i = source i finished and fully drained.
- done_all  out  1  registered; all three done_src bits high.
- overflow  out  3  sticky; bit i = a word from source i was dropped.

Behaviour:
- Reset: rst==0 sampled at posedge clears every register, including mid-operation.
  - Reset values: out_valid=0, out_data=0, out_src=0, done_src=0, done_all=0, overflow=0.
  - All queue counts and pointers = 0, so src_ready=3'b111.
  - Round-robin pointer rr=0; source 0 has highest priority after reset.
- Queue push:
  - src_valid[i] && src_ready[i] writes src_data slice i at the write pointer; the pointer wraps modulo DEPTH.
  - src_valid[i] && !src_ready[i] drops the word, sets overflow[i] and leaves the queue unchanged.
- Output stage:
  - Loads when !out_valid || out_ready (empty, or emptying this cycle).
  - On load, the arbiter picks the first non-empty queue scanning rr, rr+1, rr+2 (mod 3).
  - That queue's head goes to out_data and its index to out_src; out_valid=1; that queue pops; rr becomes (granted index + 1) mod 3.
  - If all queues are empty when the stage empties, out_valid drops to 0 and out_data/out_src hold their last values.
  - While out_valid && !out_ready: out_valid, out_data and out_src hold stable and no queue pops.
- Latency: a word pushed at edge k into an idle block shows out_valid=1 after edge k+1. Back-to-back throughput is 1 word/cycle with out_ready held high.
- Simultaneous push and pop on the same queue: the count is unchanged. A queue that is full at the start of the cycle still reports src_ready=0 that cycle, even if it pops.
- Push into an empty queue cannot be granted in the same cycle; there is no bypass.
- Done tracking:
  - src_done[i] sets sticky flag d[i] and is never cleared except by reset.
  - done_src[i] registers high on the edge after all of: d[i]=1, queue i empty, and no pending output word from source i (!(out_valid && out_src==i)).
  - done_src[i] stays high once set.
  - done_all = registered AND of the three conditions above; it rises in the same cycle as the last done_src bit.
  - Words arriving after done_src[i] is high are still queued and output. They set overflow[i] as a protocol-violation marker but do not clear done_src.
- Width rules: queue counts are log2(DEPTH)+1 bits; pointers are log2(DEPTH) bits; rr is 2 bits taking only the values 0..2.

Test Plan:
- Reset then idle: rst=0 for 3 cycles, then rst=1 with no stimulus -> out_valid=0, src_ready=3'b111, done_src=0, overflow=0 throughout.
- Single word: push 8'h41 on src 1 at edge k with out_ready=1 -> out_valid=1, out_data=8'h41, out_src=1 after edge k+1; out_valid=0 one cycle later.
- Round-robin fairness:
  - Preload three words in each queue (src0 8'h01-03, src1 8'h11-13, src2 8'h21-23), out_ready=1.
  - Required output order: 01,11,21,02,12,22,03,13,23, with no idle cycle between words.
- Backpressure and overflow:
  - Hold out_ready=0 and push 5 words into src 0 with DEPTH=4.
  - Required: word 1 sits in the output register, words 2-5 fill the queue, src_ready[0]=0, overflow=0.
  - A 6th push sets overflow[0]=1. out_data holds the first word while stalled.
  - Release out_ready -> words 1-5 emerge in order.
- Done sequencing:
  - Push 2 words on src 2 and pulse src_done[2] in the same cycle, with out_ready=1.
  - done_src[2] rises only on the edge after the second word is accepted by the sink.
  - done_all stays 0 until src_done[0] and src_done[1] have also been seen with their queues drained.
- Reset mid-operation: assert rst=0 while queues are partly full and out_valid=1 -> the next cycle shows out_valid=0, all counts 0, done_src=0, overflow=0, and rr restarts at source 0.
